// File: rtl/ddr_wr_burst.sv
// DDR write-burst transmitter: sequences DQS preamble, BL/2 data beat pairs and postamble
// into the D0/D1/OE inputs of the per-pin DDR output flops.
// Optional feature macro: DDR_WR_SEAMLESS_EN (back-to-back bursts without pre/postamble).
module ddr_wr_burst #(
  parameter int unsigned DQ_W = 16,
  parameter int unsigned BL   = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_start,
  output logic                  o_start_ready,
  input  logic [2*DQ_W-1:0]     i_wr_data,
  input  logic [2*(DQ_W/8)-1:0] i_wr_mask,
  input  logic                  i_wr_valid,
  output logic                  o_wr_ready,
  output logic [DQ_W-1:0]       o_dq_d0,
  output logic [DQ_W-1:0]       o_dq_d1,
  output logic [DQ_W/8-1:0]     o_dm_d0,
  output logic [DQ_W/8-1:0]     o_dm_d1,
  output logic                  o_dqs_d0,
  output logic                  o_dqs_d1,
  output logic                  o_dq_oe,
  output logic                  o_dqs_oe,
  output logic                  o_busy,
  output logic                  o_underrun
);

  localparam int unsigned DM_W = DQ_W / 8;
  localparam int unsigned Half = BL / 2;
  localparam int unsigned CntW = $clog2(Half);
  localparam logic [CntW-1:0] LastCnt = CntW'(Half - 1);

  typedef enum logic [1:0] {StIdle, StPre, StData, StPost} state_e;

  state_e          r_state;
  logic [CntW-1:0] r_cnt;
  logic [DQ_W-1:0] r_dq_d0;
  logic [DQ_W-1:0] r_dq_d1;
  logic [DM_W-1:0] r_dm_d0;
  logic [DM_W-1:0] r_dm_d1;
  logic            r_dqs_d0;
  logic            r_dqs_d1;
  logic            r_dq_oe;
  logic            r_dqs_oe;
  logic            r_underrun;

  logic w_last;
  logic w_start_ready;
  logic w_accept;

  assign w_last = (r_state == StData) && (r_cnt == LastCnt);

`ifdef DDR_WR_SEAMLESS_EN
  // A start in the final beat cycle chains straight into the next burst.
  assign w_start_ready = (r_state == StIdle) || w_last;
`else
  assign w_start_ready = (r_state == StIdle);
`endif

  assign w_accept = i_start && w_start_ready;

  // Burst sequencer with registered pin outputs; pins lag the state by one cycle.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state    <= StIdle;
      r_cnt      <= '0;
      r_dq_d0    <= '0;
      r_dq_d1    <= '0;
      r_dm_d0    <= '0;
      r_dm_d1    <= '0;
      r_dqs_d0   <= 1'b0;
      r_dqs_d1   <= 1'b0;
      r_dq_oe    <= 1'b0;
      r_dqs_oe   <= 1'b0;
      r_underrun <= 1'b0;
    end else begin
      r_dqs_d1   <= 1'b0;
      r_underrun <= 1'b0;
      unique case (r_state)
        StIdle: begin
          r_state  <= w_accept ? StPre : StIdle;
          r_cnt    <= '0;
          r_dq_d0  <= '0;
          r_dq_d1  <= '0;
          r_dm_d0  <= '0;
          r_dm_d1  <= '0;
          r_dqs_d0 <= 1'b0;
          r_dq_oe  <= 1'b0;
          r_dqs_oe <= 1'b0;
        end
        StPre: begin
          r_state  <= StData;
          r_cnt    <= '0;
          r_dq_d0  <= '0;
          r_dq_d1  <= '0;
          r_dm_d0  <= '0;
          r_dm_d1  <= '0;
          r_dqs_d0 <= 1'b0;
          r_dq_oe  <= 1'b0;
          r_dqs_oe <= 1'b1;
        end
        StData: begin
          r_dqs_d0 <= 1'b1;
          r_dq_oe  <= 1'b1;
          r_dqs_oe <= 1'b1;
          if (i_wr_valid) begin
            r_dq_d0 <= i_wr_data[DQ_W-1:0];
            r_dq_d1 <= i_wr_data[2*DQ_W-1:DQ_W];
            r_dm_d0 <= i_wr_mask[DM_W-1:0];
            r_dm_d1 <= i_wr_mask[2*DM_W-1:DM_W];
          end else begin
            // Timing cannot stall: repeat old data but mask every byte.
            r_dm_d0    <= '1;
            r_dm_d1    <= '1;
            r_underrun <= 1'b1;
          end
          if (r_cnt == LastCnt) begin
            r_cnt   <= '0;
            r_state <= w_accept ? StData : StPost;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        StPost: begin
          r_state  <= StIdle;
          r_cnt    <= '0;
          r_dq_d0  <= '0;
          r_dq_d1  <= '0;
          r_dm_d0  <= '0;
          r_dm_d1  <= '0;
          r_dqs_d0 <= 1'b0;
          r_dq_oe  <= 1'b0;
          r_dqs_oe <= 1'b1;
        end
        default: begin
          r_state <= StIdle;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign o_start_ready = w_start_ready;
  assign o_wr_ready    = (r_state == StData);
  assign o_busy        = (r_state != StIdle);
  assign o_dq_d0       = r_dq_d0;
  assign o_dq_d1       = r_dq_d1;
  assign o_dm_d0       = r_dm_d0;
  assign o_dm_d1       = r_dm_d1;
  assign o_dqs_d0      = r_dqs_d0;
  assign o_dqs_d1      = r_dqs_d1;
  assign o_dq_oe       = r_dq_oe;
  assign o_dqs_oe      = r_dqs_oe;
  assign o_underrun    = r_underrun;

endmodule

// File: tb/tb_ddr_wr_burst.sv
// Bench for ddr_wr_burst: BL=4 and BL=8 instances share stimulus; a cycle timeline model
// predicts every control/pin value. Honours DDR_WR_SEAMLESS_EN when defined.
module tb_ddr_wr_burst;

  localparam int N = 48;
`ifdef DDR_WR_SEAMLESS_EN
  localparam bit Seam = 1'b1;
`else
  localparam bit Seam = 1'b0;
`endif

  // {start_ready, wr_ready, busy, dq_oe, dqs_oe, dqs_d0, dqs_d1, underrun,
  //  dm_d0, dm_d1, dq_d0, dq_d1}
  typedef logic [43:0] obs_t;
  typedef enum int {RIdle, RPre, RData, RPost} role_e;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] wr_data = '0;
  logic [3:0]  wr_mask = '0;
  logic        wr_valid = 1'b0;

  logic [1:0]  sr, wrr, bz, dqoe, dqsoe, s0, s1, und;
  logic [15:0] d0 [2];
  logic [15:0] d1 [2];
  logic [1:0]  m0 [2];
  logic [1:0]  m1 [2];

  bit          st_a [N];
  bit          rs_a [N];
  bit          vl_a [N];
  logic [31:0] dt_a [N];
  logic [3:0]  mk_a [N];

  obs_t obs_v [2][N];
  obs_t exp_v [2][N];
  obs_t msk_v [2][N];

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  ddr_wr_burst #(.DQ_W(16), .BL(4)) u_dut4 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .o_start_ready(sr[0]),
    .i_wr_data(wr_data), .i_wr_mask(wr_mask), .i_wr_valid(wr_valid), .o_wr_ready(wrr[0]),
    .o_dq_d0(d0[0]), .o_dq_d1(d1[0]), .o_dm_d0(m0[0]), .o_dm_d1(m1[0]),
    .o_dqs_d0(s0[0]), .o_dqs_d1(s1[0]), .o_dq_oe(dqoe[0]), .o_dqs_oe(dqsoe[0]),
    .o_busy(bz[0]), .o_underrun(und[0])
  );

  ddr_wr_burst #(.DQ_W(16), .BL(8)) u_dut8 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .o_start_ready(sr[1]),
    .i_wr_data(wr_data), .i_wr_mask(wr_mask), .i_wr_valid(wr_valid), .o_wr_ready(wrr[1]),
    .o_dq_d0(d0[1]), .o_dq_d1(d1[1]), .o_dm_d0(m0[1]), .o_dm_d1(m1[1]),
    .o_dqs_d0(s0[1]), .o_dqs_d1(s1[1]), .o_dq_oe(dqoe[1]), .o_dqs_oe(dqsoe[1]),
    .o_busy(bz[1]), .o_underrun(und[1])
  );

  // Default stimulus: reset in cycle 0, then idle with valid random data.
  task automatic clear_stim();
    for (int c = 0; c < N; c++) begin
      st_a[c] = 1'b0;
      rs_a[c] = (c != 0);
      vl_a[c] = 1'b1;
      dt_a[c] = $urandom;
      mk_a[c] = 4'h0;
    end
  endtask

  // Timeline model: each accepted start books PRE, BL/2 DATA cycles and POST ahead of time.
  task automatic build_expect(input int d);
    int          h;
    role_e       role [N+8];
    bit          lst  [N+8];
    logic [31:0] pd;
    logic [40:0] p;
    obs_t        m;
    bit          rdy;
    int          b;
    h  = (d == 0) ? 2 : 4;
    pd = '0;
    for (int i = 0; i < N + 8; i++) begin
      role[i] = RIdle;
      lst[i]  = 1'b0;
    end
    for (int c = 0; c < N; c++) begin
      exp_v[d][c] = '0;
      msk_v[d][c] = '1;
    end
    for (int c = 0; c < N; c++) begin
      rdy = (role[c] == RIdle) || (Seam && role[c] == RData && lst[c]);
      exp_v[d][c][43:41] = {rdy, role[c] == RData, role[c] != RIdle};
      p = '0;
      m = '1;
      if (!rs_a[c]) begin
        for (int j = c + 1; j < N + 8; j++) begin
          role[j] = RIdle;
          lst[j]  = 1'b0;
        end
        pd = '0;
      end else begin
        if (st_a[c] && rdy) begin
          b = (role[c] == RIdle) ? c + 2 : c + 1;
          if (role[c] == RIdle) role[c+1] = RPre;
          for (int k = 0; k < h; k++) begin
            role[b+k] = RData;
            lst[b+k]  = (k == h - 1);
          end
          role[b+h] = RPost;
          lst[b+h]  = 1'b0;
        end
        case (role[c])
          RPre, RPost: begin
            p  = {4'b0100, 1'b0, 36'h0};
            m  = {8'hFF, 36'h0};
            pd = '0;
          end
          RData: begin
            if (vl_a[c]) begin
              pd = {dt_a[c][15:0], dt_a[c][31:16]};
              p  = {4'b1110, 1'b0, mk_a[c][1:0], mk_a[c][3:2], pd};
            end else begin
              p = {4'b1110, 1'b1, 4'hF, pd};
            end
          end
          default: pd = '0;
        endcase
      end
      if (c + 1 < N) begin
        exp_v[d][c+1][40:0] = p;
        msk_v[d][c+1]       = m;
      end
    end
  endtask

  // Apply one stimulus table, record both DUTs at mid-cycle, then build expectations.
  task automatic run_stim();
    for (int c = 0; c < N; c++) begin
      @(posedge clk);
      #1;
      start    = st_a[c];
      rst_n    = rs_a[c];
      wr_valid = vl_a[c];
      wr_data  = dt_a[c];
      wr_mask  = mk_a[c];
      @(negedge clk);
      for (int d = 0; d < 2; d++)
        obs_v[d][c] = {sr[d], wrr[d], bz[d], dqoe[d], dqsoe[d], s0[d], s1[d], und[d],
                       m0[d], m1[d], d0[d], d1[d]};
    end
    start    = 1'b0;
    wr_valid = 1'b0;
    build_expect(0);
    build_expect(1);
  endtask

  task automatic test_reset();
    clear_stim();
    rs_a[1] = 1'b0;
    rs_a[2] = 1'b0;
    st_a[1] = 1'b1;
    run_stim();
    for (int d = 0; d < 2; d++) begin
      n_checks++;
      if (obs_v[d][2] !== {3'b100, 41'h0})
        $display("FAIL reset_state bl%0d got %h exp %h", d * 4 + 4, obs_v[d][2], {3'b100, 41'h0});
      else n_pass++;
    end
    for (int c = 1; c < N; c++)
      for (int d = 0; d < 2; d++) begin
        n_checks++;
        if ((obs_v[d][c] & msk_v[d][c]) !== (exp_v[d][c] & msk_v[d][c]))
          $display("FAIL reset_model bl%0d cyc %0d got %h exp %h", d * 4 + 4, c,
                   obs_v[d][c], exp_v[d][c]);
        else n_pass++;
      end
  endtask

  task automatic test_basic();
    int busy_n;
    clear_stim();
    st_a[2] = 1'b1;
    dt_a[4] = 32'hBBBB_AAAA;
    dt_a[5] = 32'hDDDD_CCCC;
    run_stim();
    n_checks++;
    if (obs_v[0][4][40:37] !== 4'b0100)
      $display("FAIL basic_pre got %b exp %b", obs_v[0][4][40:37], 4'b0100);
    else n_pass++;
    n_checks++;
    if ({obs_v[0][5][40:37], obs_v[0][5][31:0]} !== {4'b1110, 32'hAAAA_BBBB})
      $display("FAIL basic_beat0 got %h exp %h", {obs_v[0][5][40:37], obs_v[0][5][31:0]},
               {4'b1110, 32'hAAAA_BBBB});
    else n_pass++;
    n_checks++;
    if ({obs_v[0][6][40:37], obs_v[0][6][31:0]} !== {4'b1110, 32'hCCCC_DDDD})
      $display("FAIL basic_beat1 got %h exp %h", {obs_v[0][6][40:37], obs_v[0][6][31:0]},
               {4'b1110, 32'hCCCC_DDDD});
    else n_pass++;
    n_checks++;
    if (obs_v[0][7][40:37] !== 4'b0100)
      $display("FAIL basic_post got %b exp %b", obs_v[0][7][40:37], 4'b0100);
    else n_pass++;
    n_checks++;
    if (obs_v[0][8][40:0] !== 41'h0)
      $display("FAIL basic_idle got %h exp 0", obs_v[0][8][40:0]);
    else n_pass++;
    busy_n = 0;
    for (int c = 1; c < N; c++) busy_n += int'(obs_v[0][c][41]);
    n_checks++;
    if (busy_n != 4) $display("FAIL basic_busy_cycles got %0d exp 4", busy_n);
    else n_pass++;
    for (int c = 1; c < N; c++)
      for (int d = 0; d < 2; d++) begin
        n_checks++;
        if ((obs_v[d][c] & msk_v[d][c]) !== (exp_v[d][c] & msk_v[d][c]))
          $display("FAIL basic_model bl%0d cyc %0d got %h exp %h", d * 4 + 4, c,
                   obs_v[d][c], exp_v[d][c]);
        else n_pass++;
      end
  endtask

  task automatic test_underrun();
    int und_n;
    clear_stim();
    st_a[2] = 1'b1;
    dt_a[5] = 32'h2222_1111;
    vl_a[6] = 1'b0;
    run_stim();
    n_checks++;
    if (obs_v[1][7][36:0] !== {1'b1, 4'hF, 32'h1111_2222})
      $display("FAIL underrun_beat got %h exp %h", obs_v[1][7][36:0], {1'b1, 4'hF, 32'h1111_2222});
    else n_pass++;
    n_checks++;
    if ({obs_v[1][8][40], obs_v[1][8][36]} !== 2'b10)
      $display("FAIL underrun_last_beat got %b exp 10", {obs_v[1][8][40], obs_v[1][8][36]});
    else n_pass++;
    n_checks++;
    if (obs_v[1][9][40:37] !== 4'b0100)
      $display("FAIL underrun_post got %b exp %b", obs_v[1][9][40:37], 4'b0100);
    else n_pass++;
    und_n = 0;
    for (int c = 1; c < N; c++) und_n += int'(obs_v[1][c][36]);
    n_checks++;
    if (und_n != 1) $display("FAIL underrun_pulses got %0d exp 1", und_n);
    else n_pass++;
    for (int c = 1; c < N; c++)
      for (int d = 0; d < 2; d++) begin
        n_checks++;
        if ((obs_v[d][c] & msk_v[d][c]) !== (exp_v[d][c] & msk_v[d][c]))
          $display("FAIL underrun_model bl%0d cyc %0d got %h exp %h", d * 4 + 4, c,
                   obs_v[d][c], exp_v[d][c]);
        else n_pass++;
      end
  endtask

  task automatic test_mask();
    clear_stim();
    st_a[2] = 1'b1;
    mk_a[4] = 4'b0110;
    run_stim();
    n_checks++;
    if (obs_v[0][5][35:32] !== 4'b1001)
      $display("FAIL mask_split got %b exp %b", obs_v[0][5][35:32], 4'b1001);
    else n_pass++;
    for (int c = 1; c < N; c++)
      for (int d = 0; d < 2; d++) begin
        n_checks++;
        if ((obs_v[d][c] & msk_v[d][c]) !== (exp_v[d][c] & msk_v[d][c]))
          $display("FAIL mask_model bl%0d cyc %0d got %h exp %h", d * 4 + 4, c,
                   obs_v[d][c], exp_v[d][c]);
        else n_pass++;
      end
  endtask

  task automatic test_back_to_back();
    clear_stim();
    st_a[2] = 1'b1;
    st_a[5] = 1'b1;
    run_stim();
`ifdef DDR_WR_SEAMLESS_EN
    for (int c = 5; c <= 8; c++) begin
      n_checks++;
      if (obs_v[0][c][40:37] !== 4'b1110)
        $display("FAIL seamless_beats cyc %0d got %b exp %b", c, obs_v[0][c][40:37], 4'b1110);
      else n_pass++;
    end
    n_checks++;
    if (obs_v[0][9][40:37] !== 4'b0100)
      $display("FAIL seamless_post got %b exp %b", obs_v[0][9][40:37], 4'b0100);
    else n_pass++;
`else
    n_checks++;
    if ({obs_v[0][7][41], obs_v[0][7][40:37]} !== 5'b00100)
      $display("FAIL b2b_ignored got %b exp %b", {obs_v[0][7][41], obs_v[0][7][40:37]}, 5'b00100);
    else n_pass++;
    n_checks++;
    if (obs_v[0][8][41:0] !== 42'h0)
      $display("FAIL b2b_idle got %h exp 0", obs_v[0][8][41:0]);
    else n_pass++;
`endif
    for (int c = 1; c < N; c++)
      for (int d = 0; d < 2; d++) begin
        n_checks++;
        if ((obs_v[d][c] & msk_v[d][c]) !== (exp_v[d][c] & msk_v[d][c]))
          $display("FAIL b2b_model bl%0d cyc %0d got %h exp %h", d * 4 + 4, c,
                   obs_v[d][c], exp_v[d][c]);
        else n_pass++;
      end
  endtask

  task automatic test_reset_mid_burst();
    clear_stim();
    st_a[2] = 1'b1;
    rs_a[5] = 1'b0;
    run_stim();
    n_checks++;
    if (obs_v[0][6] !== {3'b100, 41'h0})
      $display("FAIL midreset_state got %h exp %h", obs_v[0][6], {3'b100, 41'h0});
    else n_pass++;
    n_checks++;
    if (obs_v[0][7][39] !== 1'b0)
      $display("FAIL midreset_no_post got %b exp 0", obs_v[0][7][39]);
    else n_pass++;
    for (int c = 1; c < N; c++)
      for (int d = 0; d < 2; d++) begin
        n_checks++;
        if ((obs_v[d][c] & msk_v[d][c]) !== (exp_v[d][c] & msk_v[d][c]))
          $display("FAIL midreset_model bl%0d cyc %0d got %h exp %h", d * 4 + 4, c,
                   obs_v[d][c], exp_v[d][c]);
        else n_pass++;
      end
  endtask

  task automatic test_random();
    for (int it = 0; it < 8; it++) begin
      clear_stim();
      for (int c = 1; c < N; c++) begin
        st_a[c] = ($urandom_range(0, 2) == 0);
        vl_a[c] = ($urandom_range(0, 4) != 0);
        rs_a[c] = ($urandom_range(0, 30) != 0);
        mk_a[c] = 4'($urandom_range(0, 15));
      end
      run_stim();
      for (int c = 1; c < N; c++)
        for (int d = 0; d < 2; d++) begin
          n_checks++;
          if ((obs_v[d][c] & msk_v[d][c]) !== (exp_v[d][c] & msk_v[d][c]))
            $display("FAIL random_model it %0d bl%0d cyc %0d got %h exp %h", it, d * 4 + 4, c,
                     obs_v[d][c], exp_v[d][c]);
          else n_pass++;
        end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_underrun();
    test_mask();
    test_back_to_back();
    test_reset_mid_burst();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ddr_wr_burst.md
# ddr_wr_burst

Write-burst transmitter for the versatile memory controller's DDR data path: the sending end of the DQ/DQS interface whose capture side is the DDR input flop pair. Accepts a write command and a stream of 2×DQ_W-bit words from the write data buffer. Sequences DQS preamble, data beats and postamble. Drives the D0/D1 inputs and output enables of the per-pin ddr_ff_out instances, one clock per DDR beat pair.

## Interface
Parameters:
- DQ_W, 16, DQ width in bits; multiple of 8. DM_W = DQ_W/8.
- BL, 4, burst length in beats; 4 or 8. The burst occupies BL/2 clock cycles.

Ports:
- clk  in  1  controller clock; the DDR output flops use the same clock.
- rst_n  in  1  reset; synchronous and active-low.
- start  in  1  write command issued; accepted when start && start_ready.
- start_ready  out  1  block can accept start this cycle.
- wr_data  in  2*DQ_W  [DQ_W-1:0] is the rising beat, [2*DQ_W-1:DQ_W] is the falling beat.
- wr_mask  in  2*DM_W  byte masks, same split; 1 = byte masked.
- wr_valid  in  1  wr_data/wr_mask valid.
- wr_ready  out  1  word consumed when wr_valid && wr_ready.
- dq_d0, dq_d1  out  DQ_W each  to ddr_ff_out D0/D1 of the DQ pins.
- dm_d0, dm_d1  out  DM_W each  to ddr_ff_out D0/D1 of the DM pins.
- dqs_d0, dqs_d1  out  1 each  DQS pattern.
- dq_oe, dqs_oe  out  1 each  tristate enables.
- busy  out  1  FSM not in IDLE.
- underrun  out  1  one-cycle pulse, aligned with the masked beat pair.

## Operation
- FSM states: IDLE, PRE, DATA, POST. A beat counter runs 0..BL/2-1 in DATA.
- IDLE: start_ready=1. On start, go to PRE.
- PRE: one cycle, then DATA with counter=0.
- DATA: wr_ready=1. The counter increments every cycle; DATA never stalls because DDR timing is fixed. At the last count, go to POST.
  - With the seamless feature, an accepted start in the last DATA cycle instead goes to DATA with counter=0.
- POST: one cycle, then IDLE. start_ready=0.
- Output registers update at the edge that ends each state cycle, so pin values lag the FSM state by one cycle:
  - after IDLE: all outputs 0.
  - after PRE: dqs_oe=1, dqs_d0=0, dqs_d1=0, dq_oe=0.
  - after DATA: dqs_oe=1, dq_oe=1, dqs_d0=1, dqs_d1=0. dq_d0/dq_d1/dm_d0/dm_d1 take the low/high halves of wr_data/wr_mask.
  - after POST: dqs_oe=1, dq_oe=0, dqs_d0=0, dqs_d1=0.
- Underrun: in a DATA cycle with wr_valid=0, dq_d0/dq_d1 hold their previous values, dm_d0/dm_d1 are all ones, and underrun pulses for that beat pair. The burst still completes on schedule.
- wr_ready and start_ready are combinational from the state. busy = (state != IDLE).
- Reset: rst_n=0 at any edge forces IDLE, counter 0, and every output register to 0, including mid-burst. No postamble is emitted after reset.

## Timing
- Start accepted at edge E0; state=PRE after E0.
- E1: preamble on pins; state=DATA; wr_ready=1.
- E1+k: beat pair k on pins, for k=1..BL/2.
- Edge after the last beat pair: postamble on pins.
- Next edge: all outputs idle (0).
- Start-to-first-data latency: 2 cycles.
- Non-seamless minimum gap between bursts: POST plus IDLE plus PRE cycles.
- Seamless: beat pair 0 of the next burst directly follows the last beat pair of the previous one. No postamble or preamble in between; dq_oe and dqs_oe stay 1.

## Configuration
- DDR_WR_SEAMLESS_EN defined: start_ready is also 1 in the last DATA cycle, and back-to-back bursts follow the seamless rule above.
- DDR_WR_SEAMLESS_EN undefined: start_ready is 1 only in IDLE. start in any other state is ignored and does not queue.

## Test plan
- BL=4, DQ_W=16. Reset, then start with words 0xBBBB_AAAA and 0xDDDD_CCCC, wr_valid=1, mask 0 -> on pins:
  - one preamble cycle (dqs_oe=1, dqs 0/0);
  - then d0/d1 = AAAA/BBBB, then CCCC/DDDD, with dq_oe=1 and dqs 1/0;
  - then postamble;
  - then all outputs 0. busy high for 4 cycles.
- BL=8, wr_valid low on the 3rd DATA cycle, previous word 0x2222_1111 -> third beat pair shows 1111/2222 with dm_d0=dm_d1=2'b11 and a one-cycle underrun pulse. The burst still ends after 4 beat pairs.
- wr_mask=4'b0110 on word 0 -> dm_d0=2'b10 and dm_d1=2'b01 on that beat pair.
- Seamless, BL=4, start asserted in the last DATA cycle -> 4 consecutive beat pairs with dq_oe continuously 1 and a single preamble/postamble. Without the macro, the same stimulus is ignored and busy drops after POST.
- rst_n=0 during the 2nd DATA cycle -> next edge shows all outputs 0, start_ready=1, busy=0, and no postamble.
